// File: rtl/mmio_periph_pkg.sv
// Shared constants for the memory-mapped I/O peripheral: bus command
// encodings and register offsets within the peripheral window.
package mmio_periph_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b11;

  localparam logic [6:0] OFF_OUT0    = 7'h00;
  localparam logic [6:0] OFF_IN_LVL  = 7'h40;
  localparam logic [6:0] OFF_IN_EDGE = 7'h41;
  localparam logic [6:0] OFF_TIMER   = 7'h42;

endpackage

// File: rtl/mmio_periph_if.sv
// CPU data-bus interface between the core (master) and memory-mapped
// slaves such as mmio_periph.
interface mmio_periph_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;
  logic              rd_hit;

  modport master (output mem_cmd, mem_addr, w_data, input r_data, rd_hit);
  modport slave  (input mem_cmd, mem_addr, w_data, output r_data, rd_hit);
endinterface

// File: rtl/mmio_in_sync.sv
// Two-flop synchroniser for asynchronous input pins, followed by a prev
// flop and sticky rising-edge flags with a write-1-to-clear mask.
module mmio_in_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pins,
  input  logic [W-1:0] clr,
  output logic [W-1:0] lvl,
  output logic [W-1:0] edges
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;
  logic [W-1:0] prev_q;
  logic [W-1:0] edge_q;

  // NOTE: all state updates use <= so every flop samples the pre-edge value
  // of its neighbour; blocking = here would collapse the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      // A new rise wins over a simultaneous clear of the same bit.
      edge_q  <= (edge_q & ~clr) | (sync2_q & ~prev_q);
    end
  end

  assign lvl   = sync2_q;
  assign edges = edge_q;

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped peripheral: writable output registers, synchronised input
// port with sticky edge capture, and a prescaled free-running timer.
module mmio_periph
  import mmio_periph_pkg::*;
#(
  parameter int              DATA_W    = 16,
  parameter int              ADDR_W    = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 9'h100,
  parameter int              NUM_OUT   = 2,
  parameter int              OUT_W     = 10,
  parameter int              IN_W      = 10,
  parameter int              PRESCALE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  mmio_periph_if.slave             bus,
  input  logic [IN_W-1:0]          in_pins,
  output logic [NUM_OUT*OUT_W-1:0] out_bus
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [ADDR_W-1:0] diff;
  logic              in_win;
  logic [6:0]        off;
  logic              cmd_rd;
  logic              cmd_wr;
  logic              hit_lvl;
  logic              hit_edge;
  logic              hit_tmr;
  logic [NUM_OUT-1:0] hit_out;

  // The window is 128 words; anything below the base or past the top misses.
  assign diff     = bus.mem_addr - BASE_ADDR;
  assign in_win   = (bus.mem_addr >= BASE_ADDR) && (diff[ADDR_W-1:7] == '0);
  assign off      = diff[6:0];
  assign cmd_rd   = (bus.mem_cmd == MREAD);
  assign cmd_wr   = (bus.mem_cmd == MWRITE);
  assign hit_lvl  = in_win && (off == OFF_IN_LVL);
  assign hit_edge = in_win && (off == OFF_IN_EDGE);
  assign hit_tmr  = in_win && (off == OFF_TIMER);

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit_out = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      hit_out[k] = in_win && (off == OFF_OUT0 + 7'(k));
    end
  end

  // Output registers, packed so register k lands on out_bus[k*OUT_W +: OUT_W].
  logic [NUM_OUT-1:0][OUT_W-1:0] out_q;

  // NOTE: this register file is tiny and drives pins, so it is reset
  // explicitly; large RAM arrays would normally be left unreset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
    end else if (cmd_wr) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (hit_out[k]) out_q[k] <= bus.w_data[OUT_W-1:0];
      end
    end
  end

  assign out_bus = out_q;

  logic [IN_W-1:0] in_lvl;
  logic [IN_W-1:0] in_edge;
  logic [IN_W-1:0] edge_clr;

  assign edge_clr = (cmd_wr && hit_edge) ? bus.w_data[IN_W-1:0] : '0;

  mmio_in_sync #(.W(IN_W)) u_in_sync (
    .clk   (clk),
    .reset (reset),
    .pins  (in_pins),
    .clr   (edge_clr),
    .lvl   (in_lvl),
    .edges (in_edge)
  );

  logic [15:0]      tmr_count;
  logic [15:0]      count_nxt;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_nxt;

  // A TIMER write beats a same-cycle increment; the count wraps silently.
  always_comb begin
    count_nxt = tmr_count;
    pre_nxt   = pre_q;
    if (cmd_wr && hit_tmr) begin
      count_nxt = '0;
      pre_nxt   = '0;
    end else if (pre_q == PRE_W'(PRESCALE - 1)) begin
      count_nxt = tmr_count + 16'd1;
      pre_nxt   = '0;
    end else begin
      pre_nxt   = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmr_count <= '0;
      pre_q     <= '0;
    end else begin
      tmr_count <= count_nxt;
      pre_q     <= pre_nxt;
    end
  end

  always_comb begin
    bus.r_data = '0;
    bus.rd_hit = 1'b0;
    if (cmd_rd) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (hit_out[k]) begin
          bus.r_data = DATA_W'(out_q[k]);
          bus.rd_hit = 1'b1;
        end
      end
      if (hit_lvl) begin
        bus.r_data = DATA_W'(in_lvl);
        bus.rd_hit = 1'b1;
      end
      if (hit_edge) begin
        bus.r_data = DATA_W'(in_edge);
        bus.rd_hit = 1'b1;
      end
      if (hit_tmr) begin
        bus.r_data = DATA_W'(tmr_count);
        bus.rd_hit = 1'b1;
      end
    end
  end

  // Upper write-data bits are legitimately ignored by narrow registers.
  logic unused_w_data;
  assign unused_w_data = ^bus.w_data;

endmodule

// File: doc/mmio_periph.md
Name: mmio_periph

Overview:
- Parametrised memory-mapped I/O peripheral on the CPU data bus (mem_cmd/mem_addr/w_data/r_data), replacing the fixed single-LED/single-switch decode.
- Provides NUM_OUT writable output registers, a synchronised input port with sticky rising-edge capture, and a prescaled free-running timer.
- All registers sit in one address window at BASE_ADDR. RAM and the top-level read mux sit alongside it, and the mux selects r_data when rd_hit=1.

Parameters:
- DATA_W, 16: bus data width.
- ADDR_W, 9: bus address width.
- BASE_ADDR, 9'h100: window base; the window spans BASE_ADDR..BASE_ADDR+8'h7F.
- NUM_OUT, 2: number of output registers (1..64).
- OUT_W, 10: width of each output register (≤ DATA_W).
- IN_W, 10: input port width (≤ DATA_W).
- PRESCALE, 1: timer increments once every PRESCALE clocks (≥1).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-low reset. It is sampled on the rising edge of clk.
- mem_cmd, input, 2: bus command; 2'b00 NONE, 2'b01 READ, 2'b11 WRITE. 2'b10 is treated as NONE.
- mem_addr, input, ADDR_W: bus address.
- w_data, input, DATA_W: write data.
- r_data, output, DATA_W: read data, combinational; it is 0 when rd_hit=0.
- rd_hit, output, 1: asserted when the current READ hits a mapped register.
- in_pins, input, IN_W: asynchronous external inputs, e.g. SW.
- out_bus, output, NUM_OUT*OUT_W: register k drives bits [k*OUT_W +: OUT_W], e.g. LEDR.

Behaviour:
- Address map, as offset = mem_addr − BASE_ADDR:
  - 0x00..NUM_OUT-1: OUT[k]. Read/write.
  - 0x40: IN_LVL. Read-only; returns the synchronised in_pins.
  - 0x41: IN_EDGE. Sticky rising-edge flags; write-1-to-clear.
  - 0x42: TIMER. Read returns the count; any write zeroes it.
  - All other offsets, and addresses outside the window, are unmapped.
- Unmapped addresses:
  - rd_hit=0 and r_data=0.
  - Writes are ignored.
  - Writes to IN_LVL are ignored.
- Reads:
  - Combinational, zero latency: r_data and rd_hit are valid in the same cycle as mem_cmd=READ.
  - Narrower registers are zero-extended to DATA_W.
  - Reads have no side effects.
- Writes:
  - Take effect at the rising edge where mem_cmd=WRITE and the address hits.
  - OUT[k] <= w_data[OUT_W-1:0].
  - Read-after-write in the next cycle returns the new value.
- Input path, per bit:
  - Two-flop synchroniser, then a "prev" flop.
  - rise = sync2 & ~prev.
  - IN_LVL = sync2, so in_pins reaches IN_LVL 2 clocks after it changes.
  - A rise sets its IN_EDGE bit one clock after IN_LVL goes high.
- IN_EDGE update: edge <= (edge & ~clr) | rise, where clr = w_data[IN_W-1:0] when an IN_EDGE write occurs, else 0.
  - If a new rise coincides with a clear of the same bit, the set wins and the bit stays 1.
  - Falling edges are not captured.
- Timer:
  - 16-bit count, plus a prescale counter of width clog2(PRESCALE).
  - The count increments when the prescale counter reaches PRESCALE-1; the prescale counter then returns to 0.
  - The count wraps 16'hFFFF -> 0 silently.
  - A TIMER write zeroes both the count and the prescale counter. A write takes priority over an increment in the same cycle.
- Reset, active whenever reset=0 at a clock edge:
  - All OUT registers, synchroniser flops, prev flops, IN_EDGE, the count and the prescale counter go to 0.
  - out_bus therefore reads 0 one cycle after reset is asserted.
  - Bus writes during reset are ignored.
  - If in_pins is held high through reset release, the rise is captured, and IN_EDGE sets 3 clocks after release.
- mem_addr and w_data are don't-care when mem_cmd is NONE.

Decomposition:
- Shared package:
  - Bus command constants MNONE=2'b00, MREAD=2'b01, MWRITE=2'b11.
  - Register offset constants OFF_OUT0=7'h00, OFF_IN_LVL=7'h40, OFF_IN_EDGE=7'h41, OFF_TIMER=7'h42.
- Sub-module mmio_in_sync, parameter W: contains the synchroniser, prev flop and sticky edge register, with a clear-mask input.
  - Instantiated once with W=IN_W.
- Address decode, OUT registers, timer and read mux stay in mmio_periph.

Test Plan:
- Reset, then write 16'h03A5 to 9'h100 and 16'hFFFF to 9'h101 → out_bus[9:0]=10'h3A5 and out_bus[19:10]=10'h3FF. A read of 9'h101 returns r_data=16'h03FF with rd_hit=1.
- in_pins=10'h0AA, wait 2 clocks → a read of 9'h140 returns 16'h00AA. A read of 9'h150 returns rd_hit=0, r_data=0. A write to 9'h140 changes nothing.
- Toggle in_pins[3] 0→1→0 → a read of 9'h141 returns 16'h0008. Write 16'h0008 to 9'h141 → the read returns 0. A new rise on bit 3 in the same cycle as the clear → the bit stays 1.
- PRESCALE=4: run 40 clocks after reset → TIMER reads 10. Write 9'h142 → TIMER reads 0 on the next cycle. Force the count to 16'hFFFF → it wraps to 0.
- Hold reset=0 for 1 clock mid-run with OUT, IN_EDGE and TIMER nonzero → all read 0 afterwards. A WRITE issued during reset has no effect.
- mem_cmd=2'b10 to 9'h100 with w_data=16'h0123 → OUT[0] is unchanged and rd_hit=0.
